// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: program counter and instruction memory issuing one registered word per un-stalled RUN cycle
module instr_fetch_stage #(
   parameter int          ADDR_W    = 5,
   parameter int          DEPTH     = 32,
   parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              LoadEn,
   input  logic [ADDR_W-1:0] LoadAddr,
   input  logic [31:0]       LoadData,
   input  logic              Go,
   input  logic              Stall,
   output logic [31:0]       InstrOut,
   output logic              WriteEnable,
   output logic [ADDR_W-1:0] PC,
   output logic              Running,
   output logic              Halted
);
   typedef enum logic [1:0] {LOAD = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
   state_t            state, state_n;
   logic [31:0]       mem [DEPTH];
   logic [31:0]       word, instr_n;
   logic              we_n, load_ok;
   logic [ADDR_W-1:0] pc_n;
   assign word    = mem[PC];
   assign load_ok = state == LOAD && LoadEn && int'(LoadAddr) < DEPTH;
   // program memory is written only while loading and survives reset
   always_ff @(posedge clk)
      if (!rst && load_ok) mem[LoadAddr] <= LoadData;
   // next-state, next-PC and next-issue decode; stall falls through the held defaults
   always_comb begin
      state_n = state;
      pc_n    = PC;
      instr_n = InstrOut;
      we_n    = WriteEnable;
      case (state)
         LOAD: begin
            instr_n = '0;
            we_n    = 1'b0;
            pc_n    = '0;
            state_n = Go ? RUN : LOAD;
         end
         RUN: if (!Stall) begin
            if (word == HALT_WORD) begin
               instr_n = '0;
               we_n    = 1'b0;
               state_n = HALT;
            end else begin
               instr_n = word;
               we_n    = word != '0;
               pc_n    = PC == LAST ? PC : PC + ADDR_W'(1);
               state_n = PC == LAST ? HALT : RUN;
            end
         end
         HALT: begin
            instr_n = '0;
            we_n    = 1'b0;
         end
         default: begin
            instr_n = '0;
            we_n    = 1'b0;
            pc_n    = '0;
            state_n = LOAD;
         end
      endcase
   end
   // state, PC and the S1-facing outputs, with status flags decoded from the state being entered
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= LOAD;
         PC          <= '0;
         InstrOut    <= '0;
         WriteEnable <= 1'b0;
         Running     <= 1'b0;
         Halted      <= 1'b0;
      end else begin
         state       <= state_n;
         PC          <= pc_n;
         InstrOut    <= instr_n;
         WriteEnable <= we_n;
         Running     <= state_n == RUN;
         Halted      <= state_n == HALT;
      end
   end
endmodule
